// File: rtl/reaction_pkg.sv
// Shared types and constants for the reaction-timer game: state encodings,
// counter widths and the LFSR feedback polynomial.
package reaction_pkg;

    typedef enum logic [2:0] {
        ST_IDLE        = 3'd0,
        ST_ARMED       = 3'd1,
        ST_GO          = 3'd2,
        ST_DONE        = 3'd3,
        ST_FALSE_START = 3'd4,
        ST_TIMEOUT     = 3'd5
    } state_t;

    localparam int DELAY_W = 16;
    localparam int GO_W    = 14;

    // Taps 16, 14, 13, 11 of x^16 + x^14 + x^13 + x^11 + 1 (bits 15, 13, 12, 10).
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        return {v[14:0], ^(v & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/lfsr16.sv
// Free-running 16-bit Fibonacci LFSR, maximal length, so a nonzero seed
// never reaches the all-zero lock-up state.
module lfsr16
    import reaction_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        reset,
    output logic [15:0] q
);

    if (SEED == 16'h0000) begin : g_bad_seed
        $error("lfsr16: SEED must be nonzero");
    end

    logic [15:0] lfsr_q;
    logic [15:0] lfsr_d;

    always_comb begin
        lfsr_d = lfsr_step(lfsr_q);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lfsr_q <= SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign q = lfsr_q;

endmodule

// File: rtl/reaction_controller.sv
// Reaction-timer control FSM: random arming delay, GO window with timeout,
// false-start detection, and start/stop/clear controls for the ms counter.
module reaction_controller
    import reaction_pkg::*;
#(
    parameter int          MIN_DELAY_MS = 1000,
    parameter int          RANGE_W      = 11,
    parameter int          TIMEOUT_MS   = 9999,
    parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
    input  logic       clk_1ms,
    input  logic       reset,
    input  logic       btn_start,
    input  logic       btn_react,
    output logic       timer_start,
    output logic       timer_stop,
    output logic       timer_clear,
    output logic       led_go,
    output logic       led_fail,
    output logic       result_valid,
    output logic [2:0] state_o
);

    if (MIN_DELAY_MS + (2 ** RANGE_W) - 1 > 65535) begin : g_bad_delay
        $error("reaction_controller: MIN_DELAY_MS + 2^RANGE_W - 1 exceeds delay_cnt range");
    end
    if (TIMEOUT_MS < 1 || TIMEOUT_MS > 16383) begin : g_bad_timeout
        $error("reaction_controller: TIMEOUT_MS must be 1..16383");
    end

    state_t               state_q, state_d;
    logic                 btn_start_q, btn_react_q;
    logic [DELAY_W-1:0]   delay_cnt_q, delay_cnt_d;
    logic [GO_W-1:0]      go_cnt_q, go_cnt_d;
    logic                 timer_start_q, timer_start_d;
    logic                 timer_stop_q, timer_stop_d;
    logic                 timer_clear_q, timer_clear_d;
    logic                 led_go_q, led_go_d;
    logic                 led_fail_q, led_fail_d;
    logic                 result_valid_q, result_valid_d;

    logic [15:0]          lfsr;
    logic                 unused_lfsr_bits;
    logic                 start_edge;
    logic                 react_edge;
    logic [DELAY_W-1:0]   delay_load;
    logic                 go_last;

    lfsr16 #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .clk   (clk_1ms),
        .reset (reset),
        .q     (lfsr)
    );

    // Only the low RANGE_W bits feed the delay; the rest stay for display reuse.
    assign unused_lfsr_bits = ^lfsr;

    assign start_edge = btn_start & ~btn_start_q;
    assign react_edge = btn_react & ~btn_react_q;
    assign delay_load = DELAY_W'(MIN_DELAY_MS) + DELAY_W'(lfsr[RANGE_W-1:0]);
    assign go_last    = (go_cnt_q == GO_W'(TIMEOUT_MS - 1));

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of every other flop, independent of order.
    always_ff @(posedge clk_1ms or posedge reset) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            btn_start_q    <= 1'b0;
            btn_react_q    <= 1'b0;
            delay_cnt_q    <= '0;
            go_cnt_q       <= '0;
            timer_start_q  <= 1'b0;
            timer_stop_q   <= 1'b1;
            timer_clear_q  <= 1'b0;
            led_go_q       <= 1'b0;
            led_fail_q     <= 1'b0;
            result_valid_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            btn_start_q    <= btn_start;
            btn_react_q    <= btn_react;
            delay_cnt_q    <= delay_cnt_d;
            go_cnt_q       <= go_cnt_d;
            timer_start_q  <= timer_start_d;
            timer_stop_q   <= timer_stop_d;
            timer_clear_q  <= timer_clear_d;
            led_go_q       <= led_go_d;
            led_fail_q     <= led_fail_d;
            result_valid_q <= result_valid_d;
        end
    end

    // NOTE: every always_comb output gets a default first, so no path can
    // leave a value unassigned and infer a latch.
    always_comb begin
        state_d     = state_q;
        delay_cnt_d = delay_cnt_q;
        go_cnt_d    = go_cnt_q;
        case (state_q)
            ST_IDLE, ST_DONE, ST_FALSE_START, ST_TIMEOUT: begin
                if (start_edge) begin
                    state_d     = ST_ARMED;
                    delay_cnt_d = delay_load;
                end
            end
            ST_ARMED: begin
                delay_cnt_d = delay_cnt_q - 1'b1;
                // A react on the expiry cycle is still a false start.
                if (react_edge) begin
                    state_d = ST_FALSE_START;
                end else if (delay_cnt_q <= DELAY_W'(1)) begin
                    state_d  = ST_GO;
                    go_cnt_d = '0;
                end
            end
            ST_GO: begin
                go_cnt_d = go_cnt_q + 1'b1;
                // A react on the timeout cycle still counts as a result.
                if (react_edge) begin
                    state_d = ST_DONE;
                end else if (go_last) begin
                    state_d = ST_TIMEOUT;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Outputs are decoded from the next state and registered, so they line
    // up with state_q and are glitch-free at the counter.
    always_comb begin
        timer_start_d  = (state_d == ST_GO) || (state_d == ST_DONE) || (state_d == ST_TIMEOUT);
        timer_stop_d   = (state_d != ST_GO);
        timer_clear_d  = (state_d == ST_ARMED) && (state_q != ST_ARMED);
        led_go_d       = (state_d == ST_GO);
        led_fail_d     = (state_d == ST_FALSE_START) || (state_d == ST_TIMEOUT);
        result_valid_d = (state_d == ST_DONE) && (state_q != ST_DONE);
    end

    assign timer_start  = timer_start_q;
    assign timer_stop   = timer_stop_q;
    assign timer_clear  = timer_clear_q;
    assign led_go       = led_go_q;
    assign led_fail     = led_fail_q;
    assign result_valid = result_valid_q;
    assign state_o      = state_q;

endmodule

// File: tb/tb_reaction_controller.sv
// Directed self-checking bench for reaction_controller with a short delay
// (10..13 ms) and a 50 ms GO window; an LFSR model predicts each delay.
module tb_reaction_controller;

    localparam int MIN_D = 10;
    localparam int RW    = 2;
    localparam int TMO   = 50;

    localparam logic [15:0] S_IDLE  = 16'd0;
    localparam logic [15:0] S_ARMED = 16'd1;
    localparam logic [15:0] S_GO    = 16'd2;
    localparam logic [15:0] S_DONE  = 16'd3;
    localparam logic [15:0] S_FS    = 16'd4;
    localparam logic [15:0] S_TMO   = 16'd5;

    logic       clk_1ms = 1'b0;
    logic       reset   = 1'b1;
    logic       btn_start = 1'b0;
    logic       btn_react = 1'b0;
    logic       timer_start, timer_stop, timer_clear;
    logic       led_go, led_fail, result_valid;
    logic [2:0] state_o;

    int          vectors    = 0;
    int          miscompares = 0;
    int          run_cnt    = 0;
    int          d_exp      = 0;
    logic [15:0] lfsr_m;

    reaction_controller #(
        .MIN_DELAY_MS (MIN_D),
        .RANGE_W      (RW),
        .TIMEOUT_MS   (TMO),
        .LFSR_SEED    (16'hACE1)
    ) dut (
        .clk_1ms      (clk_1ms),
        .reset        (reset),
        .btn_start    (btn_start),
        .btn_react    (btn_react),
        .timer_start  (timer_start),
        .timer_stop   (timer_stop),
        .timer_clear  (timer_clear),
        .led_go       (led_go),
        .led_fail     (led_fail),
        .result_valid (result_valid),
        .state_o      (state_o)
    );

    always #5 clk_1ms = ~clk_1ms;

    // Reference LFSR: feedback = q15 ^ q13 ^ q12 ^ q10, shifted in at bit 0.
    always @(posedge clk_1ms or posedge reset) begin
        if (reset) begin
            lfsr_m <= 16'hACE1;
        end else begin
            lfsr_m <= {lfsr_m[14:0], lfsr_m[15] ^ lfsr_m[13] ^ lfsr_m[12] ^ lfsr_m[10]};
        end
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance one cycle; outputs are sampled on the falling edge.
    task automatic tick();
        @(posedge clk_1ms);
        @(negedge clk_1ms);
        if (timer_start && !timer_stop) run_cnt++;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_state"},  16'(state_o), S_IDLE);
        check({tag, "_stop"},   16'(timer_stop), 16'd1);
        check({tag, "_start"},  16'(timer_start), 16'd0);
        check({tag, "_clear"},  16'(timer_clear), 16'd0);
        check({tag, "_go"},     16'(led_go), 16'd0);
        check({tag, "_fail"},   16'(led_fail), 16'd0);
        check({tag, "_valid"},  16'(result_valid), 16'd0);
    endtask

    // Press start for one cycle; ends in the first ARMED cycle.
    task automatic press_start(input string tag);
        btn_start = 1'b1;
        d_exp = MIN_D + int'(lfsr_m[RW-1:0]);
        tick();
        btn_start = 1'b0;
        check({tag, "_armed"}, 16'(state_o), S_ARMED);
        check({tag, "_clear1"}, 16'(timer_clear), 16'd1);
    endtask

    // From the first ARMED cycle, run to the first GO cycle (D cycles of ARMED).
    task automatic run_to_go(input string tag);
        tick();
        check({tag, "_clear0"}, 16'(timer_clear), 16'd0);
        repeat (d_exp - 2) tick();
        check({tag, "_armed_last"}, 16'(state_o), S_ARMED);
        check({tag, "_go_pre"}, 16'(led_go), 16'd0);
        tick();
        check({tag, "_go_state"}, 16'(state_o), S_GO);
        check({tag, "_go_led"}, 16'(led_go), 16'd1);
    endtask

    initial begin
        // 1: reset, a short burst of activity, then reset again mid-stream.
        repeat (2) @(negedge clk_1ms);
        check_idle("t1_por");
        reset = 1'b0;
        tick();
        press_start("t1");
        repeat (3) tick();
        #2 reset = 1'b1;
        #1 check_idle("t1_midreset");
        @(negedge clk_1ms);
        reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            check("t1_hold_state", 16'(state_o), S_IDLE);
            check("t1_hold_stop", 16'(timer_stop), 16'd1);
        end

        // 2: normal game, react in the 25th GO cycle.
        run_cnt = 0;
        press_start("t2");
        run_to_go("t2");
        repeat (24) tick();
        btn_react = 1'b1;
        tick();
        check("t2_done", 16'(state_o), S_DONE);
        check("t2_valid1", 16'(result_valid), 16'd1);
        btn_react = 1'b0;
        tick();
        check("t2_valid0", 16'(result_valid), 16'd0);
        check("t2_hold_done", 16'(state_o), S_DONE);
        check("t2_run_cycles", 16'(run_cnt), 16'd25);

        // 3: react 5 cycles into ARMED.
        run_cnt = 0;
        press_start("t3");
        repeat (4) tick();
        btn_react = 1'b1;
        tick();
        check("t3_fs", 16'(state_o), S_FS);
        check("t3_fail", 16'(led_fail), 16'd1);
        check("t3_go", 16'(led_go), 16'd0);
        check("t3_stop", 16'(timer_stop), 16'd1);
        btn_react = 1'b0;
        tick();
        check("t3_run_cycles", 16'(run_cnt), 16'd0);

        // 4a: react on the delay-expiry cycle.
        press_start("t4a");
        repeat (d_exp - 1) tick();
        check("t4a_last_armed", 16'(state_o), S_ARMED);
        btn_react = 1'b1;
        tick();
        check("t4a_fs", 16'(state_o), S_FS);
        btn_react = 1'b0;
        tick();

        // 4b: react on the 50th (timeout) GO cycle.
        press_start("t4b");
        run_to_go("t4b");
        repeat (TMO - 1) tick();
        check("t4b_go50", 16'(state_o), S_GO);
        btn_react = 1'b1;
        tick();
        check("t4b_done", 16'(state_o), S_DONE);
        check("t4b_valid", 16'(result_valid), 16'd1);
        btn_react = 1'b0;
        tick();

        // 5: no react, timeout after 50 GO cycles, then restart.
        run_cnt = 0;
        press_start("t5");
        run_to_go("t5");
        repeat (TMO - 1) tick();
        check("t5_go50", 16'(state_o), S_GO);
        tick();
        check("t5_timeout", 16'(state_o), S_TMO);
        check("t5_fail", 16'(led_fail), 16'd1);
        check("t5_go_off", 16'(led_go), 16'd0);
        check("t5_run_cycles", 16'(run_cnt), 16'(TMO));
        press_start("t5r");
        check("t5r_fail0", 16'(led_fail), 16'd0);
        run_to_go("t5r");
        btn_react = 1'b1;
        tick();
        check("t5r_done", 16'(state_o), S_DONE);

        // 6: react held across start into GO, then release/press; reset mid-GO.
        press_start("t6");
        run_to_go("t6");
        btn_react = 1'b0;
        tick();
        check("t6_still_go", 16'(state_o), S_GO);
        btn_react = 1'b1;
        tick();
        check("t6_done", 16'(state_o), S_DONE);
        btn_react = 1'b0;
        tick();
        press_start("t6b");
        run_to_go("t6b");
        repeat (3) tick();
        #2 reset = 1'b1;
        #1 check_idle("t6_reset_go");
        @(negedge clk_1ms);
        reset = 1'b0;
        tick();
        check("t6_post_reset", 16'(state_o), S_IDLE);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
